// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the SRAM request bridge: access-size encodings,
// the default response depth and the alignment rule.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    localparam int RESP_DEPTH_DEF = 3;

    // The reserved size behaves as a full word, so it needs word alignment.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sram_req_bridge_if.sv
// Request/response handshake plus single-port SRAM signals for sram_req_bridge.
// The master side is the requester and SRAM model; the slave side is the bridge.
interface sram_req_bridge_if
    import sram_bridge_pkg::*;
#(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [1:0]              req_size;
    logic [LEN_ADDR-1:0]     req_addr;
    logic [LEN_DATA-1:0]     req_wdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [LEN_DATA-1:0]     resp_rdata;
    logic                    resp_err;
    logic [LEN_ADDR-1:0]     addra;
    logic [LEN_DATA-1:0]     dina;
    logic                    ena;
    logic [LEN_DATA/8-1:0]   wea;
    logic [LEN_DATA-1:0]     douta;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready, douta,
        input  req_ready, resp_valid, resp_rdata, resp_err, addra, dina, ena, wea
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready, douta,
        output req_ready, resp_valid, resp_rdata, resp_err, addra, dina, ena, wea
    );

endinterface

// File: rtl/sram_req_bridge_resp_fifo.sv
// Small synchronous FIFO holding read responses; exposes its occupancy so the
// bridge can throttle requests before the queue could overflow.
module resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_req_bridge.sv
// Bridges a valid/ready byte-addressed request stream onto a single-port SRAM
// with one-cycle read latency, queuing read data for a valid/ready response port.
module sram_req_bridge
    import sram_bridge_pkg::*;
#(
    parameter int LEN_ADDR   = 32,
    parameter int LEN_DATA   = 32,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input logic          clk,
    input logic          resetn,
    sram_req_bridge_if.slave bus
);
    localparam int LANES = LEN_DATA / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int CW    = $clog2(RESP_DEPTH + 1);

    size_e               size_p0;
    logic [OFFW-1:0]     off_p0;
    logic                mis_p0;
    logic                accept_p0;
    logic [LANES-1:0]    lane_mask_p0;
    logic [LEN_DATA-1:0] dina_p0;
    logic                rd_vld_p1;
    logic                err_p1;
    logic [CW-1:0]       count;
    logic [CW:0]         occupancy;
    logic [LEN_DATA:0]   fifo_dout;
    logic                pop;

    // Stage p0: request decode and SRAM drive, all combinational.
    assign size_p0   = size_e'(bus.req_size);
    assign off_p0    = bus.req_addr[OFFW-1:0];
    assign mis_p0    = is_misaligned(size_p0, bus.req_addr[1:0]);

    // The in-flight read counts against capacity so its push always has a slot.
    assign occupancy     = {1'b0, count} + {{CW{1'b0}}, rd_vld_p1};
    assign bus.req_ready = resetn && (occupancy < (CW+1)'(RESP_DEPTH));
    assign accept_p0     = bus.req_valid && bus.req_ready;

    assign bus.ena   = accept_p0 && !mis_p0;
    assign bus.addra = {bus.req_addr[LEN_ADDR-1:OFFW], {OFFW{1'b0}}};
    assign bus.wea   = (bus.ena && bus.req_wr) ? lane_mask_p0 : '0;
    assign bus.dina  = dina_p0;

    always_comb begin
        case (size_p0)
            SZ_BYTE: lane_mask_p0 = LANES'(1) << off_p0;
            SZ_HALF: lane_mask_p0 = LANES'(3) << off_p0;
            default: lane_mask_p0 = '1;
        endcase
    end

    always_comb begin
        dina_p0 = bus.req_wdata;
        for (int i = 0; i < LANES; i++) begin
            case (size_p0)
                SZ_BYTE: dina_p0[i*8 +: 8] = bus.req_wdata[7:0];
                SZ_HALF: dina_p0[i*8 +: 8] = bus.req_wdata[(i % 2)*8 +: 8];
                default: dina_p0[i*8 +: 8] = bus.req_wdata[i*8 +: 8];
            endcase
        end
    end

    // Stage p1: SRAM data returns; capture it with the error tag into the queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= accept_p0 && !bus.req_wr;
        end
    end

    always_ff @(posedge clk) begin
        err_p1 <= mis_p0;
    end

    resp_fifo #(
        .WIDTH (LEN_DATA + 1),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rd_vld_p1),
        .din    ({bus.douta, err_p1}),
        .pop    (pop),
        .dout   (fifo_dout),
        .count  (count)
    );

    // Stage p2: queue head drives the response port.
    assign bus.resp_valid = (count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_rdata = fifo_dout[LEN_DATA:1];
    assign bus.resp_err   = fifo_dout[0];

endmodule

// File: tb/tb_sram_req_bridge.sv
// Self-checking bench for sram_req_bridge: request-side vector table, a read
// response scoreboard against a byte-level shadow memory, and corner sequences.
module tb_sram_req_bridge;
    import sram_bridge_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_req_bridge_if #(.LEN_ADDR(32), .LEN_DATA(32)) bus ();

    sram_req_bridge #(.LEN_ADDR(32), .LEN_DATA(32), .RESP_DEPTH(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Word-organised SRAM with registered read data.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.ena) begin
            for (int j = 0; j < 4; j++) begin
                if (bus.wea[j]) mem[bus.addra[9:2]][j*8 +: 8] <= bus.dina[j*8 +: 8];
            end
            bus.douta <= mem[bus.addra[9:2]];
        end
    end

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ena;
        logic [3:0]  wea;
        logic [31:0] addra;
        logic [31:0] dina;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t        vecs [14];
    resp_t       sbq [$];
    logic [7:0]  shb [1024];
    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] pattern(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0103);
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic set_req(input bit v, input bit wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    // Called at the sampling edge: record the effect of an accepted request.
    task automatic note_accept();
        logic [9:0] a;
        resp_t      r;
        if (bus.req_valid && bus.req_ready) begin
            a = bus.req_addr[9:0];
            if (bus.req_wr) begin
                if (!misal(bus.req_size, bus.req_addr)) begin
                    case (bus.req_size)
                        2'd0: shb[a] = bus.req_wdata[7:0];
                        2'd1: begin
                            shb[a]      = bus.req_wdata[7:0];
                            shb[a + 1]  = bus.req_wdata[15:8];
                        end
                        default: for (int j = 0; j < 4; j++) shb[a + 10'(j)] = bus.req_wdata[j*8 +: 8];
                    endcase
                end
            end else begin
                a[1:0] = 2'b00;
                r.rdata = {shb[a + 3], shb[a + 2], shb[a + 1], shb[a]};
                r.err   = misal(bus.req_size, bus.req_addr);
                sbq.push_back(r);
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        note_accept();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (mon_en && bus.resp_valid && bus.resp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 64'(bus.resp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("resp_err", 64'(bus.resp_err), 64'(e.err));
                if (!e.err) chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{1'b1, 2'd0, 32'h13, 32'h0000_00AB, 1'b1, 4'b1000, 32'h10, 32'hABAB_ABAB},
            '{1'b1, 2'd0, 32'h10, 32'h0000_0011, 1'b1, 4'b0001, 32'h10, 32'h1111_1111},
            '{1'b1, 2'd1, 32'h22, 32'h1234_BEEF, 1'b1, 4'b1100, 32'h20, 32'hBEEF_BEEF},
            '{1'b1, 2'd1, 32'h21, 32'h0000_5555, 1'b0, 4'b0000, 32'h20, 32'h0},
            '{1'b1, 2'd2, 32'h20, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h20, 32'hDEAD_BEEF},
            '{1'b1, 2'd3, 32'h30, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h30, 32'hCAFE_F00D},
            '{1'b1, 2'd2, 32'h32, 32'h0000_0077, 1'b0, 4'b0000, 32'h30, 32'h0},
            '{1'b0, 2'd2, 32'h20, 32'h0,         1'b1, 4'b0000, 32'h20, 32'h0},
            '{1'b0, 2'd1, 32'h21, 32'h0,         1'b0, 4'b0000, 32'h20, 32'h0},
            '{1'b0, 2'd0, 32'h13, 32'h0,         1'b1, 4'b0000, 32'h10, 32'h0},
            '{1'b0, 2'd2, 32'h10, 32'h0,         1'b1, 4'b0000, 32'h10, 32'h0},
            '{1'b1, 2'd0, 32'h41, 32'h0000_005A, 1'b1, 4'b0010, 32'h40, 32'h5A5A_5A5A},
            '{1'b0, 2'd1, 32'h42, 32'h0,         1'b1, 4'b0000, 32'h40, 32'h0},
            '{1'b0, 2'd3, 32'h30, 32'h0,         1'b1, 4'b0000, 32'h30, 32'h0}
        };
        for (int i = 0; i < 256; i++) begin
            mem[i] = pattern(i);
            for (int j = 0; j < 4; j++) shb[i*4 + j] = pattern(i)[j*8 +: 8];
        end
        bus.resp_ready = 1'b1;
        set_req(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
        mon_en = 1'b1;

        // Reset state with a request pending.
        repeat (2) begin
            to_neg();
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_ena", 64'(bus.ena), 64'd0);
            chk("rst_wea", 64'(bus.wea), 64'd0);
            chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            to_drive();
        end
        resetn = 1'b1;
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_neg();
        to_drive();

        // Request-side decode table.
        foreach (vecs[i]) begin
            set_req(1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            to_neg();
            chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'd1);
            chk($sformatf("v%0d_ena", i), 64'(bus.ena), 64'(vecs[i].ena));
            chk($sformatf("v%0d_wea", i), 64'(bus.wea), 64'(vecs[i].wea));
            chk($sformatf("v%0d_addra", i), 64'(bus.addra), 64'(vecs[i].addra));
            if (vecs[i].wr && vecs[i].ena) chk($sformatf("v%0d_dina", i), 64'(bus.dina), 64'(vecs[i].dina));
            to_drive();
        end
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (4) begin to_neg(); to_drive(); end

        // Word write then read: response exactly two cycles after acceptance.
        set_req(1'b1, 1'b1, 2'd2, 32'h80, 32'hDEAD_BEEF);
        to_neg(); to_drive();
        set_req(1'b1, 1'b0, 2'd2, 32'h80, 32'h0);
        to_neg();
        chk("lat_accept", 64'(bus.req_ready), 64'd1);
        to_drive();
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_neg();
        chk("lat_t1_valid", 64'(bus.resp_valid), 64'd0);
        to_drive();
        to_neg();
        chk("lat_t2_valid", 64'(bus.resp_valid), 64'd1);
        chk("lat_t2_rdata", 64'(bus.resp_rdata), 64'hDEAD_BEEF);
        to_drive();

        // Backpressure: three reads fill the queue, the fourth waits.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 2'd2, 32'(i * 4), 32'h0);
            to_neg();
            chk($sformatf("bp_ready%0d", i), 64'(bus.req_ready), (i < 3) ? 64'd1 : 64'd0);
            if (i < 3) to_drive();
        end
        to_drive();
        to_neg();
        chk("bp_hold", 64'(bus.req_ready), 64'd0);
        to_drive();
        bus.resp_ready = 1'b1;
        to_neg();
        chk("bp_release_same", 64'(bus.req_ready), 64'd0);
        to_drive();
        to_neg();
        chk("bp_4th_accept", 64'(bus.req_ready), 64'd1);
        to_drive();
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (6) begin to_neg(); to_drive(); end

        // Streaming: eight reads, one per cycle, responses back to back.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_req(1'b1, 1'b0, 2'd2, 32'h100 + 32'(k * 4), 32'h0);
            else       set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            to_neg();
            if (k < 8) chk($sformatf("st_ready%0d", k), 64'(bus.req_ready), 64'd1);
            chk($sformatf("st_valid%0d", k), 64'(bus.resp_valid), (k >= 2) ? 64'd1 : 64'd0);
            to_drive();
        end
        to_neg();
        chk("st_empty", 64'(bus.resp_valid), 64'd0);
        to_drive();

        // Reset with two queued responses and one read in flight.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, 2'd2, 32'h200 + 32'(i * 4), 32'h0);
            to_neg();
            chk($sformatf("rr_ready%0d", i), 64'(bus.req_ready), 64'd1);
            to_drive();
        end
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        to_neg();
        chk("rr_pre_valid", 64'(bus.resp_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rr_valid_dropped", 64'(bus.resp_valid), 64'd0);
        chk("rr_ready_dropped", 64'(bus.req_ready), 64'd0);
        sbq.delete();
        to_drive();
        to_drive();
        resetn = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            chk($sformatf("rr_no_stale%0d", i), 64'(bus.resp_valid), 64'd0);
            to_drive();
        end
        set_req(1'b1, 1'b0, 2'd2, 32'h80, 32'h0);
        to_neg();
        chk("rr_after_ready", 64'(bus.req_ready), 64'd1);
        to_drive();
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (4) begin to_neg(); to_drive(); end

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_req_bridge.md
SRAM_REQ_BRIDGE -- requirements
Module: sram_req_bridge

Interface
REQ-001 The block SHALL have parameter LEN_ADDR, default 32, meaning the address width.
REQ-002 The block SHALL have parameter LEN_DATA, default 32, meaning the SRAM word width (byte lanes = LEN_DATA/8).
REQ-003 The block SHALL have parameter RESP_DEPTH, default 3, meaning the read-response FIFO depth.
REQ-004 clk  input  1  sole clock; SRAM port driven and sampled on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
REQ-010 req_addr  input  LEN_ADDR  byte address.
REQ-011 req_wdata  input  LEN_DATA  write data, right-aligned.
REQ-012 resp_valid  output  1  read response available.
REQ-013 resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-014 resp_rdata  output  LEN_DATA  raw SRAM word read.
REQ-015 resp_err  output  1  response belongs to a misaligned read.
REQ-016 addra, dina, ena, wea  output  LEN_ADDR, LEN_DATA, 1, LEN_DATA/8  SRAM port; douta  input  LEN_DATA  SRAM read data, valid one cycle after ena.

Function
REQ-017 req_ready SHALL be 1 iff resetn=1 and (FIFO count + read-in-flight flag) < RESP_DEPTH; the same gate applies to reads and writes.
REQ-018 ena SHALL equal req_valid && req_ready combinationally, except that misaligned requests SHALL NOT assert ena.
REQ-019 addra SHALL equal req_addr with bits [log2(LEN_DATA/8)-1:0] forced to 0.
REQ-020 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 wea (write, aligned) SHALL be: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word/reserved -> 4'hF; wea SHALL be 0 for reads and misaligned writes.
REQ-022 dina SHALL replicate req_wdata[7:0] 4x for byte, req_wdata[15:0] 2x for half, and pass req_wdata for word.
REQ-023 An accepted read (aligned or misaligned) in cycle T SHALL set the in-flight flag for cycle T+1; at the edge ending T+1, {douta, err} SHALL be pushed into the FIFO (rdata undefined when err=1).
REQ-024 Read latency SHALL be exactly 2 cycles from acceptance to resp_valid when the FIFO is empty; no combinational bypass.
REQ-025 Writes SHALL produce no response and complete in the acceptance cycle.
REQ-026 resp_valid SHALL equal (FIFO count != 0); resp_rdata and resp_err SHALL show the FIFO head.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged; push into a full FIFO SHALL be impossible by REQ-017.
REQ-028 Responses SHALL return in request order.
REQ-029 Back-to-back aligned reads with resp_ready held at 1 SHALL sustain one acceptance per cycle.

Reset
REQ-030 While resetn=0: req_ready=0, ena=0, wea=0, resp_valid=0, in-flight flag=0, FIFO count=0, pointers=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and queued responses immediately; the first acceptance SHALL occur no earlier than the first rising edge after deassertion.

Structure
REQ-032 The size encodings, RESP_DEPTH default, and a misalignment helper function SHALL reside in shared package sram_bridge_pkg.
REQ-033 The response queue SHALL be a sub-module resp_fifo (synchronous, parameterised width/depth, count output).

Verification
REQ-034 Byte write addr 0x13, wdata 0xAB -> ena=1, addra=0x10, wea=4'b1000, dina=0xABABABAB, no response.
REQ-035 Word write 0x20 = 0xDEADBEEF, then read 0x20 -> resp_valid 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-036 Half read at 0x21 -> ena stays 0, response after 2 cycles with err=1; half write at 0x21 -> wea=0.
REQ-037 Reads of 0x0,0x4,0x8,0xC with resp_ready=0 -> 3 accepted, req_ready=0 for the 4th; raising resp_ready -> 4th accepted next cycle, responses returned in order.
REQ-038 8 back-to-back reads with resp_ready=1 -> req_ready never drops, 8 in-order responses on consecutive cycles.
REQ-039 resetn pulled low with 2 queued and 1 in-flight -> resp_valid=0 immediately; after release, no stale response appears.
